// File: rtl/scd_mem_pkg.sv
// Shared definitions for the scd data memory: access sizes, control states,
// byte-lane count and small lane/alignment helpers.
package scd_mem_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = 4'b0011 << off;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/scd_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read address;
// the storage array has no reset.
module scd_ram_be #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NB = DW / 8
) (
    input  logic          i_clk,
    input  logic [NB-1:0] i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_addr;

    // Lane writes and read-address capture; a read the cycle after a write sees the new bytes
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
        r_addr <= i_addr;
    end

    assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/scd_dmem.sv
// Byte-addressable data memory: zero-fills itself after reset, performs byte/half/word
// loads and stores, rejects misaligned accesses and optionally registers load data.
module scd_dmem
    import scd_mem_pkg::*;
#(
    parameter int DW      = 32,
    parameter int WA      = 5,
    parameter int OUT_REG = 1
) (
    input  logic          memclk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] datain,
    output logic          ready,
    output logic [DW-1:0] dataout,
    output logic          dvalid,
    output logic          misalign
);

    logic [1:0]       w_off;
    logic [WA-1:0]    w_widx;
    logic             w_mis;
    logic             w_acc;
    logic             w_unused_addr;
    logic [LANES-1:0] w_ram_we;
    logic [WA-1:0]    w_ram_addr;
    logic [DW-1:0]    w_ram_wdata;
    logic [DW-1:0]    w_rdata;
    logic [DW-1:0]    w_shift;
    logic [DW-1:0]    w_ext;

    state_e           r_state;
    logic [WA-1:0]    r_clr_cnt;
    logic             r_ready;
    logic             r_p1_valid;
    logic [1:0]       r_p1_off;
    logic [1:0]       r_p1_size;
    logic             r_p1_sext;
    logic             r_dvalid;
    logic             r_misalign;
    logic [DW-1:0]    r_dout;

    assign w_off         = addr[1:0];
    assign w_widx        = addr[WA+1:2];
    assign w_unused_addr = ^addr[31:WA+2];
    assign w_mis         = is_misaligned(size, w_off);
    assign w_acc         = req & r_ready;

    // RAM port mux: the clear sweep owns the port until RUN, then aligned stores write lanes
    always_comb begin
        w_ram_we    = {LANES{1'b0}};
        w_ram_addr  = w_widx;
        w_ram_wdata = {DW{1'b0}};
        if (r_state == ST_CLEAR && !rst) begin
            w_ram_we   = {LANES{1'b1}};
            w_ram_addr = r_clr_cnt;
        end else if (w_acc && we && !w_mis) begin
            w_ram_we = lane_mask(size, w_off);
            case (size)
                SZ_BYTE: w_ram_wdata = {LANES{datain[7:0]}};
                SZ_HALF: w_ram_wdata = {(LANES/2){datain[15:0]}};
                default: w_ram_wdata = datain;
            endcase
        end else begin
            w_ram_we = {LANES{1'b0}};
        end
    end

    scd_ram_be #(.DW(DW), .AW(WA), .NB(LANES)) u_ram (
        .i_clk   (memclk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    assign w_shift = w_rdata >> {r_p1_off, 3'b000};

    // Bring the addressed lanes down to bit 0 and extend sub-word results
    always_comb begin
        case (r_p1_size)
            SZ_BYTE: w_ext = {{(DW-8){r_p1_sext & w_shift[7]}}, w_shift[7:0]};
            SZ_HALF: w_ext = {{(DW-16){r_p1_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Control FSM: sweep zeros through every word, then accept requests
    always_ff @(posedge memclk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= {WA{1'b0}};
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + {{(WA-1){1'b0}}, 1'b1};
                    if (r_clr_cnt == {WA{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_state   <= ST_RUN;
                    r_clr_cnt <= r_clr_cnt;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= {WA{1'b0}};
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Load/misalign pipeline; reset drops any load still in flight
    always_ff @(posedge memclk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_off   <= 2'b00;
            r_p1_size  <= 2'b00;
            r_p1_sext  <= 1'b0;
            r_misalign <= 1'b0;
            r_dvalid   <= 1'b0;
            r_dout     <= {DW{1'b0}};
        end else begin
            r_p1_valid <= w_acc & ~we & ~w_mis;
            r_p1_off   <= w_off;
            r_p1_size  <= size;
            r_p1_sext  <= sext;
            r_misalign <= w_acc & w_mis;
            r_dvalid   <= r_p1_valid;
            if (r_p1_valid) begin
                r_dout <= w_ext;
            end else begin
                r_dout <= r_dout;
            end
        end
    end

    // Without the output register, data bypasses r_dout only while valid so it still holds
    generate
        if (OUT_REG != 0) begin : g_oreg
            assign dataout = r_dout;
            assign dvalid  = r_dvalid;
        end else begin : g_ocomb
            assign dataout = r_p1_valid ? w_ext : r_dout;
            assign dvalid  = r_p1_valid;
        end
    endgenerate

    assign ready    = r_ready;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_scd_dmem.sv
// Self-checking bench for scd_dmem: directed scenarios plus random traffic
// compared against a byte-array memory model.
module tb_scd_dmem;

    logic        memclk = 1'b0;
    logic        rst    = 1'b1;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic        sext   = 1'b0;
    logic [1:0]  size   = 2'b00;
    logic [31:0] addr   = 32'h0;
    logic [31:0] datain = 32'h0;
    logic        ready;
    logic        dvalid;
    logic        misalign;
    logic [31:0] dataout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          r;
        bit          w;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    // Reference model: 128-byte little-endian memory plus expected-output state
    logic [7:0]  mem_m [128];
    bit          exp_ready = 1'b0;
    bit          exp_dv    = 1'b0;
    bit          exp_mis   = 1'b0;
    bit          p1_v      = 1'b0;
    logic [31:0] exp_data  = 32'h0;
    logic [31:0] p1_d      = 32'h0;

    always #5 memclk = ~memclk;

    scd_dmem #(.DW(32), .WA(5), .OUT_REG(1)) dut (
        .memclk   (memclk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .datain   (datain),
        .ready    (ready),
        .dataout  (dataout),
        .dvalid   (dvalid),
        .misalign (misalign)
    );

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [6:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx, input logic [6:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[int'(a) + i];
        if (sx && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) mem_m[int'(a) + i] = d[8*i +: 8];
    endfunction

    // Present one cycle of stimulus, advance the clock, then update expectations
    task automatic drive(input bit r, input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d);
        bit acc;
        bit mis;
        logic [31:0] ld;
        req = r; we = w; size = sz; sext = sx; addr = a; datain = d;
        acc = r && exp_ready;
        mis = model_mis(sz, a[6:0]);
        ld  = (acc && !w && !mis) ? model_load(sz, sx, a[6:0]) : 32'h0;
        if (acc && w && !mis) model_store(sz, a[6:0], d);
        @(posedge memclk); #1;
        exp_mis = acc && mis;
        exp_dv  = p1_v;
        if (p1_v) exp_data = p1_d;
        p1_v = acc && !w && !mis;
        p1_d = ld;
    endtask

    task automatic test_reset(input string tag);
        rst = 1'b1; req = 1'b0; we = 1'b0;
        @(posedge memclk); #1;
        rst = 1'b0;
        for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
        p1_v = 1'b0; exp_dv = 1'b0; exp_mis = 1'b0; exp_data = 32'h0; exp_ready = 1'b0;
        total++;
        if (dataout !== 32'h0) begin bad++; $display("FAIL %s_dataout: got %h want 00000000", tag, dataout); end
        total++;
        if (misalign !== 1'b0) begin bad++; $display("FAIL %s_misalign: got %b want 0", tag, misalign); end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (ready !== 1'b0 || dvalid !== 1'b0) begin
                bad++; $display("FAIL %s_clear: cycle %0d ready=%b dvalid=%b want 0/0", tag, i, ready, dvalid);
            end
            @(posedge memclk); #1;
        end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready_rise: got %b want 1", tag, ready); end
        exp_ready = 1'b1;
    endtask

    task automatic test_zero_after_clear(input string tag);
        op_t ops[$];
        logic [31:0] got[$];
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        foreach (ops[k]) begin
            drive(ops[k].r, ops[k].w, ops[k].sz, ops[k].sx, ops[k].a, ops[k].d);
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL %s_zero_dvalid: step %0d got %b want %b", tag, k, dvalid, exp_dv); end
            total++;
            if (dataout !== exp_data) begin bad++; $display("FAIL %s_zero_data: step %0d got %h want %h", tag, k, dataout, exp_data); end
            if (dvalid === 1'b1) got.push_back(dataout);
        end
        total++;
        if (got.size() != 2 || got[0] !== 32'h0 || got[1] !== 32'h0) begin
            bad++; $display("FAIL %s_zero_words: got %0d results want two 00000000", tag, got.size());
        end
    endtask

    task automatic test_subword();
        op_t ops[$];
        logic [31:0] got[$];
        ops.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB});
        ops.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        foreach (ops[k]) begin
            drive(ops[k].r, ops[k].w, ops[k].sz, ops[k].sx, ops[k].a, ops[k].d);
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL subword_dvalid: step %0d got %b want %b", k, dvalid, exp_dv); end
            total++;
            if (dataout !== exp_data) begin bad++; $display("FAIL subword_data: step %0d got %h want %h", k, dataout, exp_data); end
            total++;
            if (misalign !== 1'b0) begin bad++; $display("FAIL subword_misalign: step %0d got %b want 0", k, misalign); end
            if (dvalid === 1'b1) got.push_back(dataout);
        end
        total++;
        if (got.size() != 3 || got[0] !== 32'hFFFFFF88 || got[1] !== 32'h00000088 || got[2] !== 32'hFFFFAABB) begin
            bad++; $display("FAIL subword_values: got %0d results (%h %h %h) want FFFFFF88 00000088 FFFFAABB",
                            got.size(), got[0], got[1], got[2]);
        end
    endtask

    task automatic test_store_load_fwd();
        op_t ops[$];
        int dv_step;
        logic [31:0] dv_data;
        dv_step = -1;
        dv_data = 32'h0;
        ops.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A});
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        foreach (ops[k]) begin
            drive(ops[k].r, ops[k].w, ops[k].sz, ops[k].sx, ops[k].a, ops[k].d);
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL fwd_dvalid: step %0d got %b want %b", k, dvalid, exp_dv); end
            if (dvalid === 1'b1 && dv_step < 0) begin dv_step = k; dv_data = dataout; end
        end
        total++;
        if (dv_step != 2 || dv_data !== 32'h00005A00) begin
            bad++; $display("FAIL fwd_result: step %0d data %h want step 2 data 00005A00", dv_step, dv_data);
        end
    endtask

    task automatic test_misalign();
        op_t ops[$];
        logic [31:0] got[$];
        int n_mis;
        n_mis = 0;
        ops.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 32'hA1B2C3D4});
        ops.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344});
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h03, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF});
        ops.push_back('{1'b1, 1'b1, 2'b01, 1'b0, 32'h03, 32'h0000FFFF});
        ops.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF});
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        foreach (ops[k]) begin
            drive(ops[k].r, ops[k].w, ops[k].sz, ops[k].sx, ops[k].a, ops[k].d);
            total++;
            if (misalign !== exp_mis) begin bad++; $display("FAIL mis_pulse: step %0d got %b want %b", k, misalign, exp_mis); end
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL mis_dvalid: step %0d got %b want %b", k, dvalid, exp_dv); end
            if (misalign === 1'b1) n_mis++;
            if (dvalid === 1'b1) got.push_back(dataout);
        end
        total++;
        if (n_mis != 6) begin bad++; $display("FAIL mis_count: got %0d want 6", n_mis); end
        total++;
        if (got.size() != 2 || got[0] !== 32'hA1B2C3D4 || got[1] !== 32'h11223344) begin
            bad++; $display("FAIL mis_unchanged: got %0d results (%h %h) want A1B2C3D4 11223344",
                            got.size(), got[0], got[1]);
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        logic [31:0] got[$];
        int first_dv;
        int last_dv;
        first_dv = -1;
        last_dv  = -1;
        for (int i = 0; i < 4; i++) ops.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'(4*i), 32'hC0DE0000 + 32'(i)});
        for (int i = 0; i < 4; i++) ops.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'(4*i), 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        ops.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h00, 32'h0});
        foreach (ops[k]) begin
            drive(ops[k].r, ops[k].w, ops[k].sz, ops[k].sx, ops[k].a, ops[k].d);
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL b2b_dvalid: step %0d got %b want %b", k, dvalid, exp_dv); end
            if (dvalid === 1'b1) begin
                got.push_back(dataout);
                if (first_dv < 0) first_dv = k;
                last_dv = k;
            end
        end
        total++;
        if (got.size() != 4 || last_dv - first_dv != 3) begin
            bad++; $display("FAIL b2b_streak: got %0d pulses over steps %0d..%0d want 4 consecutive", got.size(), first_dv, last_dv);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got.size() != 4 || got[i] !== 32'hC0DE0000 + 32'(i)) begin
                bad++; $display("FAIL b2b_order: slot %0d got %h want %h", i, got[i], 32'hC0DE0000 + 32'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            drive($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a, $urandom);
            total++;
            if (dvalid !== exp_dv) begin bad++; $display("FAIL rand_dvalid: step %0d got %b want %b", k, dvalid, exp_dv); end
            total++;
            if (dataout !== exp_data) begin bad++; $display("FAIL rand_data: step %0d got %h want %h", k, dataout, exp_data); end
            total++;
            if (misalign !== exp_mis) begin bad++; $display("FAIL rand_misalign: step %0d got %b want %b", k, misalign, exp_mis); end
            total++;
            if (ready !== 1'b1) begin bad++; $display("FAIL rand_ready: step %0d got %b want 1", k, ready); end
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        total++;
        if (dvalid !== exp_dv || dataout !== exp_data) begin
            bad++; $display("FAIL mid_first: dvalid=%b data=%h want %b %h", dvalid, dataout, exp_dv, exp_data);
        end
        test_reset("mid");
        test_zero_after_clear("mid");
    endtask

    task automatic test_midclear();
        rst = 1'b1; req = 1'b0;
        @(posedge memclk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ready !== 1'b0) begin bad++; $display("FAIL midclear_ready: cycle %0d got %b want 0", i, ready); end
            @(posedge memclk); #1;
        end
        test_reset("restart");
        test_zero_after_clear("restart");
    endtask

    initial begin
        test_reset("por");
        test_zero_after_clear("por");
        test_subword();
        test_store_load_fwd();
        test_misalign();
        test_back_to_back();
        test_random();
        test_midstream_reset();
        test_midclear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scd_dmem.md
SCD_DMEM -- requirements
Module: scd_dmem

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter WA, default 5, word-address width; depth SHALL be 2^WA words.
REQ-003 Parameter OUT_REG, default 1, adds an output data register when 1.
REQ-004 memclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  access request.
REQ-007 we  in  1  store when 1, load when 0.
REQ-008 size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 sext  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 addr  in  32  byte address; bits above WA+1 ignored.
REQ-011 datain  in  DW  store data, right-aligned.
REQ-012 ready  out  1  block accepts a request this cycle.
REQ-013 dataout  out  DW  load result.
REQ-014 dvalid  out  1  one-cycle pulse marking a valid dataout.
REQ-015 misalign  out  1  one-cycle pulse flagging a rejected access.

Function
REQ-016 An access SHALL be accepted only when req and ready are both 1; one access per cycle.
REQ-017 Word index SHALL be addr[WA+1:2]; byte offset SHALL be addr[1:0].
REQ-018 Stores SHALL write only the addressed byte lanes (1 byte, 2 bytes or full word), with datain low bits replicated onto those lanes.
REQ-019 Load data SHALL appear with dvalid exactly 1 cycle after acceptance when OUT_REG=0, or 2 cycles after when OUT_REG=1.
REQ-020 Sub-word loads SHALL shift the selected lanes to bit 0 and extend per sext.
REQ-021 Half access with addr[0]=1, word access with addr[1:0]!=0, or size=11 SHALL be misaligned: no write, no dvalid, misalign pulsed 1 cycle after acceptance.
REQ-022 A load accepted the cycle after a store to the same word SHALL return the newly stored bytes.
REQ-023 dataout SHALL hold its last value between dvalid pulses.
REQ-024 Stores SHALL produce neither dvalid nor misalign when aligned.
REQ-025 Back-to-back loads SHALL sustain one result per cycle with no bubbles.
REQ-026 Control FSM SHALL have states CLEAR and RUN; ready=0 in CLEAR, ready=1 in RUN.
REQ-027 In CLEAR a WA-bit counter SHALL write zero to words 0..2^WA-1, one per cycle, then move to RUN after the last word.

Reset
REQ-028 On rst: FSM enters CLEAR, clear counter=0, dataout=0, dvalid=0, misalign=0, all in-flight loads discarded.
REQ-029 rst asserted mid-clear or mid-load SHALL restart the clear from word 0; no stale dvalid SHALL follow.
REQ-030 ready SHALL rise exactly 2^WA cycles after rst deasserts (32 cycles at default).

Structure
REQ-031 Size encodings, FSM state type and lane-mask width constant SHALL live in shared package scd_mem_pkg.
REQ-032 Storage SHALL be one sub-module scd_ram_be: synchronous-read RAM with per-byte write enables, registered address, no reset.
REQ-033 Lane-mask generation, extraction/extension and the FSM SHALL be in scd_dmem.

Verification
REQ-034 rst 1 cycle, release -> ready=0 for 32 cycles, then 1; loads of word 0 and word 31 return 0x00000000.
REQ-035 Store word 0x8899AABB at 0x10; load byte 0x13 with sext=1 -> 0xFFFFFF88; with sext=0 -> 0x00000088; load half 0x10 sext=1 -> 0xFFFFAABB.
REQ-036 Store byte 0x5A at 0x21, then load word 0x20 next cycle -> 0x00005A00, dvalid 2 cycles after acceptance (OUT_REG=1).
REQ-037 Load word at 0x06, half at 0x03, size=11 at 0x00 -> misalign pulses each, no dvalid, memory unchanged.
REQ-038 Four back-to-back loads 0x00,0x04,0x08,0x0C -> four consecutive dvalid cycles in order; rst mid-stream -> no further dvalid, clear restarts.
